// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture block: SPI command codes, FSM state
// encoding, buffer depth default and the status byte helper.
// Latency: n/a (package). Backpressure: n/a.
package adc_capture_pkg;

  localparam int DEPTH_DEFAULT = 256;

  localparam logic [7:0] CMD_ARM      = 8'hA1;
  localparam logic [7:0] CMD_FORCE    = 8'hA2;
  localparam logic [7:0] CMD_READ     = 8'hA3;
  localparam logic [7:0] CMD_SETLEVEL = 8'hA4;

  localparam logic [7:0] LEVEL_RESET  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  // Byte returned to the SPI master whenever the buffer is not being read out.
  function automatic logic [7:0] status_byte(state_t s);
    return {5'b0, s};
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Sample buffer: DEPTH x 8 simple dual-port RAM, one write port, one read port.
// Latency: read data valid 1 cycle after raddr is presented.
// Backpressure: none; a write and a read may occur every cycle.
//
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read port.
module capture_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Contents are deliberately not reset; the FSM never reads a location
  // before a full capture has written it.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC sample capture with SPI command interface and buffer readout.
// Latency: status on txd_data 1 cycle after a state change; buffer byte 2 cycles after READ / each rxd_flag.
// Backpressure: none; samples arriving outside ARMED/CAPTURE are dropped.
//
// Ports: clk, resetn (async, active-low); sample_valid/sample_data ADC input;
//        rxd_out/rxd_flag/spi_cs received SPI bytes; txd_data next SPI reply;
//        capture_done high in DONE or READ.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic [7:0] rxd_out,
  input  logic       rxd_flag,
  input  logic       spi_cs,
  output logic [7:0] txd_data,
  output logic       capture_done
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    level_q, prev_q, status_q, ram_rdata;
  logic          prev_vld_q, force_q, lvl_pend_q, cs_q, rd_mode_q;

  // ---------------------------------------------------------------------
  // Command decode. The byte after SETLEVEL is always data, never a command.
  // Inside READ every byte is a dummy except ARM.
  // ---------------------------------------------------------------------
  logic byte_vld, lvl_byte, cmd_vld;
  logic is_arm, is_force, is_read, is_setlevel, cs_rise;

  assign byte_vld    = rxd_flag & ~spi_cs;
  assign lvl_byte    = byte_vld & lvl_pend_q;
  assign cmd_vld     = byte_vld & ~lvl_pend_q;
  assign is_arm      = cmd_vld && (rxd_out == CMD_ARM);
  assign is_force    = cmd_vld && (rxd_out == CMD_FORCE)    && (state_q == ST_ARMED);
  assign is_read     = cmd_vld && (rxd_out == CMD_READ)     && (state_q == ST_DONE);
  assign is_setlevel = cmd_vld && (rxd_out == CMD_SETLEVEL) && (state_q != ST_READ);
  assign cs_rise     = spi_cs & ~cs_q;

  // Rising-edge trigger: previous sample must itself have arrived in ARMED.
  logic level_hit, trig;
  assign level_hit = prev_vld_q && (prev_q < level_q) && (sample_data >= level_q);
  assign trig      = (state_q == ST_ARMED) && sample_valid && !is_arm && (force_q || level_hit);

  // ARM wins over any coincident write.
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  assign ram_we    = sample_valid && !is_arm && (trig || (state_q == ST_CAPTURE));
  assign ram_waddr = trig ? '0 : wr_ptr_q;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (is_arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_ARMED:   if (trig) state_d = ST_CAPTURE;
        ST_CAPTURE: if (sample_valid && (wr_ptr_q == LAST)) state_d = ST_DONE;
        ST_DONE:    if (is_read) state_d = ST_READ;
        ST_READ:    if (cs_rise) state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs. rd_mode_q lags the state by one cycle so the RAM read
  // pipeline and the status byte switch over together.
  always_comb begin
    capture_done = (state_q == ST_DONE) || (state_q == ST_READ);
    txd_data     = rd_mode_q ? ram_rdata : status_q;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= LEVEL_RESET;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      force_q    <= 1'b0;
      lvl_pend_q <= 1'b0;
      cs_q       <= 1'b1;
      status_q   <= 8'h00;
      rd_mode_q  <= 1'b0;
    end else begin
      cs_q      <= spi_cs;
      status_q  <= status_byte(state_q);
      rd_mode_q <= (state_q == ST_READ);

      if (lvl_byte) begin
        level_q    <= rxd_out;
        lvl_pend_q <= 1'b0;
      end else if (is_setlevel) begin
        lvl_pend_q <= 1'b1;
      end

      if (is_arm) begin
        wr_ptr_q   <= '0;
        prev_vld_q <= 1'b0;
        force_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ARMED: begin
            // A FORCE coincident with a sample triggers on the following one.
            if (is_force) force_q <= 1'b1;
            if (trig) begin
              wr_ptr_q   <= AW'(1);
              force_q    <= 1'b0;
              prev_vld_q <= 1'b0;
            end else if (sample_valid) begin
              prev_q     <= sample_data;
              prev_vld_q <= 1'b1;
            end
          end
          ST_CAPTURE: if (sample_valid) wr_ptr_q <= wr_ptr_q + AW'(1);
          ST_DONE:    if (is_read) rd_ptr_q <= '0;
          // Natural wrap from LAST back to 0 at a power-of-two depth.
          ST_READ:    if (byte_vld) rd_ptr_q <= rd_ptr_q + AW'(1);
          default:    ;
        endcase
      end
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (sample_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: behavioural model of the capture
// buffer, scoreboard queue of expected readout bytes, one task per scenario.
module tb_adc_capture;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic [7:0] rxd_out = 8'h00;
  logic       rxd_flag = 1'b0;
  logic       spi_cs = 1'b1;
  logic [7:0] txd_data;
  logic       capture_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q [$];

  // Behavioural model state
  logic [2:0] m_state;
  logic [7:0] m_level, m_prev;
  bit         m_prev_vld, m_force, m_lvl_pend;
  int         m_wr;
  logic [7:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  adc_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .rxd_out      (rxd_out),
    .rxd_flag     (rxd_flag),
    .spi_cs       (spi_cs),
    .txd_data     (txd_data),
    .capture_done (capture_done)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void model_reset();
    m_state = 3'd0; m_level = 8'h80; m_prev = 8'h00;
    m_prev_vld = 0; m_force = 0; m_lvl_pend = 0; m_wr = 0;
  endfunction

  function automatic void model_arm();
    m_state = 3'd1; m_wr = 0; m_prev_vld = 0; m_force = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_lvl_pend) begin
      m_level = b; m_lvl_pend = 0;
    end else if (m_state == 3'd4) begin
      if (b == 8'hA1) model_arm();
    end else begin
      case (b)
        8'hA1: model_arm();
        8'hA2: if (m_state == 3'd1) m_force = 1;
        8'hA3: if (m_state == 3'd3) m_state = 3'd4;
        8'hA4: m_lvl_pend = 1;
        default: ;
      endcase
    end
  endfunction

  function automatic void model_sample(logic [7:0] s);
    if (m_state == 3'd1) begin
      if (m_force || (m_prev_vld && m_prev < m_level && s >= m_level)) begin
        m_mem[0] = s; m_wr = 1; m_state = 3'd2; m_force = 0; m_prev_vld = 0;
      end else begin
        m_prev = s; m_prev_vld = 1;
      end
    end else if (m_state == 3'd2) begin
      m_mem[m_wr] = s;
      if (m_wr == DEPTH - 1) m_state = 3'd3;
      m_wr = (m_wr + 1) % DEPTH;
    end
  endfunction

  // ---------------- drivers (all return on a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd_out = b; rxd_flag = 1'b1;
    @(negedge clk);
    rxd_flag = 1'b0;
    if (!spi_cs) model_byte(b);
  endtask

  task automatic send_sample(input logic [7:0] s);
    @(negedge clk);
    sample_data = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    model_sample(s);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    idle(2);
    n_total++;
    if (txd_data !== 8'h00) $display("FAIL reset_txd: got %h want 00", txd_data);
    else n_pass++;
    n_total++;
    if (capture_done !== 1'b0) $display("FAIL reset_done: got %b want 0", capture_done);
    else n_pass++;
    resetn = 1'b1;
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL post_reset_status: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
  endtask

  task automatic test_cmd_filter();
    spi_cs = 1'b0;
    send_byte(8'hA3);                    // READ in IDLE
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL read_in_idle: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    spi_cs = 1'b1;
    send_byte(8'hA1);                    // ARM with chip select high
    idle(1);
    spi_cs = 1'b0;
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL arm_cs_high: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    send_byte(8'hA1);
    idle(1);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL arm_status: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    send_byte(8'hA3);                    // READ in ARMED
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL read_in_armed: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
  endtask

  // READ, then ndummy dummy bytes; each reply is scoreboarded from the model.
  task automatic test_readout(input string tag, input int ndummy);
    logic [7:0] exp_b;
    rxd_out = 8'hA3; rxd_flag = 1'b1;
    model_byte(8'hA3);
    exp_q.push_back(m_mem[0]);
    @(negedge clk);
    rxd_flag = 1'b0;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    n_total++;
    if (txd_data !== exp_b) $display("FAIL %s rd0: got %h want %h", tag, txd_data, exp_b);
    else n_pass++;
    n_total++;
    if (capture_done !== 1'b1) $display("FAIL %s done_in_read: got %b want 1", tag, capture_done);
    else n_pass++;
    for (int i = 1; i <= ndummy; i++) begin
      rxd_out = 8'(i) & 8'h7F; rxd_flag = 1'b1;
      model_byte(rxd_out);
      exp_q.push_back(m_mem[i % DEPTH]);
      @(negedge clk);
      rxd_flag = 1'b0;
      @(negedge clk);
      exp_b = exp_q.pop_front();
      n_total++;
      if (txd_data !== exp_b) $display("FAIL %s rd%0d: got %h want %h", tag, i, txd_data, exp_b);
      else n_pass++;
    end
    spi_cs = 1'b1;
    if (m_state == 3'd4) m_state = 3'd3;
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL %s cs_exit_status: got %h want %h", tag, txd_data, {5'b0, m_state});
    else n_pass++;
    spi_cs = 1'b0;
    idle(1);
  endtask

  task automatic test_level_trigger();
    send_byte(8'hA4);
    send_byte(8'h40);
    send_byte(8'hA1);
    for (int k = 0; k < 64 + DEPTH; k++) begin
      if (k == 64 + DEPTH - 1) begin
        n_total++;
        if (capture_done !== 1'b0) $display("FAIL lvl_early_done: got %b want 0", capture_done);
        else n_pass++;
        n_total++;
        if (txd_data !== {5'b0, m_state}) $display("FAIL lvl_capture_status: got %h want %h", txd_data, {5'b0, m_state});
        else n_pass++;
      end
      send_sample(8'(k));
    end
    n_total++;
    if (capture_done !== 1'b1) $display("FAIL lvl_done: got %b want 1", capture_done);
    else n_pass++;
    idle(1);
    n_total++;
    if (txd_data !== 8'h03) $display("FAIL lvl_done_status: got %h want 03", txd_data);
    else n_pass++;
    test_readout("lvl", 257);
  endtask

  task automatic test_force();
    send_byte(8'hA1);
    for (int k = 0; k < 20; k++) send_sample(8'h90);
    idle(1);
    n_total++;
    if (txd_data !== 8'h01) $display("FAIL force_armed_status: got %h want 01", txd_data);
    else n_pass++;
    send_byte(8'hA2);
    for (int k = 0; k < DEPTH; k++) send_sample(8'h90);
    n_total++;
    if (capture_done !== 1'b1) $display("FAIL force_done: got %b want 1", capture_done);
    else n_pass++;
    idle(1);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL force_done_status: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    test_readout("force", 257);
  endtask

  task automatic test_arm_abort();
    send_byte(8'hA1);
    send_byte(8'hA2);
    for (int k = 0; k < 100; k++) send_sample(8'(8'h20 + k));
    idle(1);
    n_total++;
    if (txd_data !== 8'h02) $display("FAIL abort_capture_status: got %h want 02", txd_data);
    else n_pass++;
    // ARM coincident with the write to address 100
    @(negedge clk);
    sample_data = 8'hEE; sample_valid = 1'b1;
    rxd_out = 8'hA1; rxd_flag = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0; rxd_flag = 1'b0;
    model_byte(8'hA1);
    idle(1);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL abort_status: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    n_total++;
    if (capture_done !== 1'b0) $display("FAIL abort_done: got %b want 0", capture_done);
    else n_pass++;
    send_sample(8'h30);
    send_sample(8'h50);
    idle(1);
    n_total++;
    if (txd_data !== 8'h02) $display("FAIL abort_retrigger: got %h want 02", txd_data);
    else n_pass++;
    for (int j = 1; j < DEPTH; j++) begin
      if (j == DEPTH - 1) begin
        n_total++;
        if (capture_done !== 1'b0) $display("FAIL abort_wrptr_early: got %b want 0", capture_done);
        else n_pass++;
      end
      send_sample(8'(8'h50 + j));
    end
    n_total++;
    if (capture_done !== 1'b1) $display("FAIL abort_wrptr_done: got %b want 1", capture_done);
    else n_pass++;
    idle(1);
    test_readout("abort", 257);
  endtask

  task automatic test_reset_mid_capture();
    send_byte(8'hA1);
    send_byte(8'hA2);
    for (int k = 0; k < 50; k++) send_sample(8'(k));
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    idle(1);
    n_total++;
    if (txd_data !== 8'h00) $display("FAIL midrst_txd: got %h want 00", txd_data);
    else n_pass++;
    n_total++;
    if (capture_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", capture_done);
    else n_pass++;
    resetn = 1'b1;
    idle(2);
    send_byte(8'hA3);
    idle(2);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL midrst_no_resume: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    // Level back to 0x80: crossing 0x40 must not trigger, crossing 0x80 must.
    send_byte(8'hA1);
    send_sample(8'h3F);
    send_sample(8'h40);
    idle(1);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL midrst_level_low: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
    send_sample(8'h7F);
    send_sample(8'h80);
    idle(1);
    n_total++;
    if (txd_data !== {5'b0, m_state}) $display("FAIL midrst_level_80: got %h want %h", txd_data, {5'b0, m_state});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cmd_filter();
    test_level_trigger();
    test_force();
    test_arm_abort();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
